// File: rtl/game_sequencer_pkg.sv
// Shared encodings, widths and default timing constants for the game sequencer slice.
package game_pkg;

    localparam int unsigned SCORE_W  = 10;
    localparam int unsigned PERIOD_W = 28;

    typedef logic [SCORE_W-1:0]  score_t;
    typedef logic [PERIOD_W-1:0] period_t;

    localparam period_t DEF_PERIOD      = 28'd3000000;
    localparam period_t DEF_PERIOD_MIN  = 28'd750000;
    localparam period_t DEF_PERIOD_STEP = 28'd250000;

    // Externally reported state codes; PAUSE reports as ST_RUN.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    // Shortened period, clamped so it never drops below the floor.
    function automatic period_t next_period(input period_t cur, input period_t step,
                                            input period_t floor_p);
        if (cur <= floor_p || (cur - floor_p) < step)
            return floor_p;
        return cur - step;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button/flag inputs and status outputs exchanged between game_sequencer and its datapath.
interface game_sequencer_if;
    import game_pkg::*;

    logic       go;
    logic       stop;
    logic       jump;
    logic       collide;
    logic       load;
    logic       move;
    logic       tick;
    logic       jump_req;
    logic       paused;
    score_t     score;
    logic [1:0] state;
    period_t    period;

    modport master (
        output go, stop, jump, collide,
        input  load, move, tick, jump_req, paused, score, state, period
    );

    modport slave (
        input  go, stop, jump, collide,
        output load, move, tick, jump_req, paused, score, state, period
    );

endinterface

// File: rtl/game_sequencer_tick_divider.sv
// Scroll-step countdown: reloads on game load, counts while enabled, holds otherwise.
module tick_divider
    import game_pkg::*;
#(
    parameter period_t PERIOD = DEF_PERIOD
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    en,
    input  logic    reload,
    input  period_t period,
    output logic    tick
);

    period_t r_count;

    assign tick = en && (r_count == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_count <= PERIOD - period_t'(1);
        else if (reload)
            r_count <= PERIOD - period_t'(1);
        else if (tick)
            r_count <= period - period_t'(1);
        else if (en)
            r_count <= r_count - period_t'(1);
    end

endmodule

// File: rtl/game_sequencer.sv
// Game control FSM: button edge detection, scroll timing, jump delivery and scoring.
// Optional SPEEDUP_EN: scroll period shortens every 64 ticks, floored at PERIOD_MIN.
module game_sequencer
    import game_pkg::*;
#(
    parameter period_t PERIOD      = DEF_PERIOD,
    parameter period_t PERIOD_MIN  = DEF_PERIOD_MIN,
    parameter period_t PERIOD_STEP = DEF_PERIOD_STEP
) (
    input logic             clk,
    input logic             resetn,
    game_sequencer_if.slave bus
);

    logic       r_go_d;
    logic       r_stop_d;
    logic       r_jump_d;
    logic       w_go_edge;
    logic       w_stop_edge;
    logic       w_jump_edge;
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_pending;
    score_t     r_score;
    period_t    w_period;
    logic       w_run;
    logic       w_load;
    logic       w_tick;

    assign w_go_edge   = bus.go   & ~r_go_d;
    assign w_stop_edge = bus.stop & ~r_stop_d;
    assign w_jump_edge = bus.jump & ~r_jump_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            {r_go_d, r_stop_d, r_jump_d} <= '0;
        else
            {r_go_d, r_stop_d, r_jump_d} <= {bus.go, bus.stop, bus.jump};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go_edge) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.collide)
                    w_state_nxt = S_OVER;
                else if (w_stop_edge)
                    w_state_nxt = S_PAUSE;
            end
            S_PAUSE: if (w_stop_edge || w_go_edge) w_state_nxt = S_RUN;
            S_OVER:  if (w_go_edge) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    assign w_run  = (r_state == S_RUN);
    assign w_load = (r_state == S_LOAD);

    tick_divider #(
        .PERIOD (PERIOD)
    ) u_tick_divider (
        .clk    (clk),
        .resetn (resetn),
        .en     (w_run),
        .reload (w_load),
        .period (w_period),
        .tick   (w_tick)
    );

    // A jump edge landing on the tick itself is delivered directly, so pending only covers earlier edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_score   <= '0;
            r_pending <= 1'b0;
        end else if (w_load) begin
            r_score   <= '0;
            r_pending <= 1'b0;
        end else if (w_tick) begin
            if (r_score != '1)
                r_score <= r_score + score_t'(1);
            r_pending <= 1'b0;
        end else if (w_run && w_jump_edge) begin
            r_pending <= 1'b1;
        end
    end

`ifdef SPEEDUP_EN
    period_t r_period;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_period <= PERIOD;
        else if (w_load)
            r_period <= PERIOD;
        else if (w_tick && (r_score[5:0] == 6'h3f))
            r_period <= next_period(r_period, PERIOD_STEP, PERIOD_MIN);
    end

    assign w_period = r_period;
`else
    logic [2*PERIOD_W-1:0] w_unused_speedup_cfg;

    assign w_unused_speedup_cfg = {PERIOD_MIN, PERIOD_STEP};
    assign w_period             = PERIOD;
`endif

    always_comb begin
        bus.state = ST_IDLE;
        case (r_state)
            S_LOAD:          bus.state = ST_LOAD;
            S_RUN, S_PAUSE:  bus.state = ST_RUN;
            S_OVER:          bus.state = ST_OVER;
            default:         bus.state = ST_IDLE;
        endcase
    end

    assign bus.load     = w_load;
    assign bus.move     = w_run;
    assign bus.tick     = w_tick;
    assign bus.jump_req = w_tick & (r_pending | w_jump_edge);
    assign bus.paused   = (r_state == S_PAUSE);
    assign bus.score    = r_score;
    assign bus.period   = w_period;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with PERIOD=8, PERIOD_MIN=4, PERIOD_STEP=2.
// Vector table, directed corner sequences and random stimulus against a cycle model.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int P     = 8;
    localparam int PMIN  = 4;
    localparam int PSTEP = 2;
`ifdef SPEEDUP_EN
    localparam bit SPD = 1'b1;
`else
    localparam bit SPD = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_OVER  = 3;
    localparam int M_PAUSE = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    game_sequencer_if bus ();

    game_sequencer #(
        .PERIOD      (28'd8),
        .PERIOD_MIN  (28'd4),
        .PERIOD_STEP (28'd2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: game phase, ticks survived, RUN cycles since last reload.
    int m_phase, m_ticks, m_run, m_len;
    bit m_pend, m_pg, m_ps, m_pj;
    bit e_tick;
    bit s_tick, s_jreq, s_paused;

    typedef struct {
        bit g, s, j, c;
        int st;
        bit ld, mv, pz, tk;
        int sc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    function automatic int model_period(input int ticks);
        int steps = ticks / 64;
        int p;
`ifndef SPEEDUP_EN
        steps = 0;
`endif
        p = P - PSTEP * steps;
        return (p < PMIN) ? PMIN : p;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_ticks = 0;
        m_run   = 0;
        m_len   = P;
        m_pend  = 1'b0;
        m_pg    = 1'b0;
        m_ps    = 1'b0;
        m_pj    = 1'b0;
    endtask

    task automatic cycle(input bit g, input bit s, input bit j, input bit c);
        bit ge, se, je, ejr;
        int est, esc;
        @(negedge clk);
        bus.go = g; bus.stop = s; bus.jump = j; bus.collide = c;
        #1;
        ge = g && !m_pg;
        se = s && !m_ps;
        je = j && !m_pj;
        e_tick = (m_phase == M_RUN) && (m_run == m_len - 1);
        ejr    = e_tick && (m_pend || je);
        est    = (m_phase == M_PAUSE) ? M_RUN : m_phase;
        esc    = (m_ticks > 1023) ? 1023 : m_ticks;
        s_tick   = bus.tick;
        s_jreq   = bus.jump_req;
        s_paused = bus.paused;
        check("state",    32'(bus.state),    est);
        check("load",     32'(bus.load),     32'(m_phase == M_LOAD));
        check("move",     32'(bus.move),     32'(m_phase == M_RUN));
        check("paused",   32'(bus.paused),   32'(m_phase == M_PAUSE));
        check("tick",     32'(bus.tick),     32'(e_tick));
        check("jump_req", 32'(bus.jump_req), 32'(ejr));
        check("score",    32'(bus.score),    esc);
        check("period",   32'(bus.period),   model_period(m_ticks));
        case (m_phase)
            M_IDLE: if (ge) m_phase = M_LOAD;
            M_LOAD: begin
                m_ticks = 0; m_run = 0; m_len = P; m_pend = 1'b0;
                m_phase = M_RUN;
            end
            M_RUN: begin
                if (e_tick) begin
                    m_len  = model_period(m_ticks);
                    m_ticks++;
                    m_run  = 0;
                    m_pend = 1'b0;
                end else begin
                    m_run++;
                    if (je) m_pend = 1'b1;
                end
                if (c)       m_phase = M_OVER;
                else if (se) m_phase = M_PAUSE;
            end
            M_PAUSE: if (se || ge) m_phase = M_RUN;
            M_OVER:  if (ge) m_phase = M_LOAD;
            default: m_phase = M_IDLE;
        endcase
        m_pg = g; m_ps = s; m_pj = j;
    endtask

    // Asserted between edges so the async path is what clears the outputs.
    task automatic apply_reset(input string name);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        bus.go = 1'b0; bus.stop = 1'b0; bus.jump = 1'b0; bus.collide = 1'b0;
        #1;
        model_reset();
        check({name, "_state"},  32'(bus.state),    0);
        check({name, "_load"},   32'(bus.load),     0);
        check({name, "_move"},   32'(bus.move),     0);
        check({name, "_tick"},   32'(bus.tick),     0);
        check({name, "_jreq"},   32'(bus.jump_req), 0);
        check({name, "_paused"}, 32'(bus.paused),   0);
        check({name, "_score"},  32'(bus.score),    0);
        check({name, "_period"}, 32'(bus.period),   P);
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic run_to_tick(input string name, input int budget);
        int n = 0;
        e_tick = 1'b0;
        while (!e_tick && n < budget) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        if (!e_tick) timeout(name);
    endtask

    task automatic run_to_pos(input string name, input int pos, input int budget);
        int n = 0;
        while (!(m_phase == M_RUN && m_run == pos) && n < budget) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        if (!(m_phase == M_RUN && m_run == pos)) timeout(name);
    endtask

    task automatic run_to_ticks(input string name, input int target, input int budget);
        int n = 0;
        while (m_ticks < target && n < budget) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        if (m_ticks < target) timeout(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int jcount, tcount, pcount;
        resetn = 1'b0;
        bus.go = 1'b0; bus.stop = 1'b0; bus.jump = 1'b0; bus.collide = 1'b0;
        model_reset();
        apply_reset("reset");

        //            g  s  j  c  st ld mv pz tk sc
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 0, 0, 0});
        for (int unsigned i = 0; i < 7; i++)
            tbl.push_back('{0, 0, 0, 0, 2, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 2, 0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 2, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 2, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 2, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 2, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 2, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 2, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 2, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 3, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 3, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 2, 0, 1, 0, 0, 0});

        foreach (tbl[i]) begin
            cycle(tbl[i].g, tbl[i].s, tbl[i].j, tbl[i].c);
            check($sformatf("tbl%0d_state", i), 32'(bus.state),  tbl[i].st);
            check($sformatf("tbl%0d_load", i),  32'(bus.load),   32'(tbl[i].ld));
            check($sformatf("tbl%0d_move", i),  32'(bus.move),   32'(tbl[i].mv));
            check($sformatf("tbl%0d_pause", i), 32'(bus.paused), 32'(tbl[i].pz));
            check($sformatf("tbl%0d_tick", i),  32'(bus.tick),   32'(tbl[i].tk));
            check($sformatf("tbl%0d_score", i), 32'(bus.score),  tbl[i].sc);
        end

        // Pause 5 cycles after a tick, hold, resume: tick lands 3 cycles later.
        run_to_tick("pause_first_tick", 20);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        tcount = 0; pcount = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            cycle(0, 1, 0, 0);
            tcount += s_tick; pcount += s_paused;
        end
        cycle(0, 0, 0, 0); tcount += s_tick; pcount += s_paused;
        cycle(0, 1, 0, 0); tcount += s_tick; pcount += s_paused;
        check("pause_no_tick", tcount, 0);
        check("pause_held", pcount, 22);
        cycle(0, 0, 0, 0); tcount = s_tick;
        cycle(0, 0, 0, 0); tcount += s_tick;
        check("resume_early_tick", tcount, 0);
        cycle(0, 0, 0, 0);
        check("resume_tick_at_3", 32'(s_tick), 1);

        // Two jump edges before one tick collapse into a single request.
        run_to_tick("jump_first_tick", 20);
        jcount = 0;
        repeat (4) begin cycle(0, 0, 0, 0); jcount += s_jreq; end
        cycle(0, 0, 1, 0); jcount += s_jreq;
        cycle(0, 0, 0, 0); jcount += s_jreq;
        cycle(0, 0, 1, 0); jcount += s_jreq;
        cycle(0, 0, 0, 0); jcount += s_jreq;
        check("jump_tick", 32'(s_tick), 1);
        check("jump_on_tick", 32'(s_jreq), 1);
        cycle(0, 0, 0, 0); jcount += s_jreq;
        check("jump_count", jcount, 1);

        run_to_pos("jump_same_cycle_wait", P - 1, 20);
        cycle(0, 0, 1, 0);
        check("jump_same_tick", 32'(s_tick), 1);
        check("jump_same_req", 32'(s_jreq), 1);

        // Reset mid-RUN with the countdown at 3.
        run_to_pos("midrun_wait", 4, 20);
        apply_reset("midrun_reset");
        tcount = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0);
            tcount += s_tick;
        end
        check("midrun_no_tick", tcount, 0);
        check("midrun_idle", 32'(bus.state), 0);

        // Long run: period steps and score saturation.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        run_to_ticks("speed64", 64, 1000);
        cycle(0, 0, 0, 0);
        check("period_64", 32'(bus.period), SPD ? 6 : 8);
        run_to_ticks("speed192", 192, 2000);
        cycle(0, 0, 0, 0);
        check("period_192", 32'(bus.period), SPD ? 4 : 8);
        run_to_ticks("speed256", 256, 1000);
        cycle(0, 0, 0, 0);
        check("period_256", 32'(bus.period), SPD ? 4 : 8);
        check("score_256", 32'(bus.score), 256);
        run_to_ticks("saturate", 1030, 7000);
        cycle(0, 0, 0, 0);
        check("score_sat", 32'(bus.score), 1023);

        apply_reset("rand_reset");
        for (int unsigned i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0)
                apply_reset("rand_midreset");
            cycle($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
